// File: rtl/pw_tile_vec_reader.sv
// Vectorised pointwise tile reader: walks row -> column -> channel group, issues pipelined
// word reads against a fixed-latency memory and delivers lane-masked beats through a FWFT buffer.
module pw_tile_vec_reader #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int ADDR_W     = 32,
    parameter int DIM_W      = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DIM_W-1:0]          cfg_tile_h,
    input  logic [DIM_W-1:0]          cfg_tile_w,
    input  logic [DIM_W-1:0]          cfg_channels,
    input  logic [ADDR_W-1:0]         cfg_base_addr,
    input  logic [DIM_W-1:0]          cfg_grp_stride,
    input  logic [DIM_W-1:0]          cfg_row_stride,
    input  logic [DIM_W-1:0]          cfg_col_stride,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [LANES*DATA_W-1:0]   rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [LANES-1:0]          out_lane_mask,
    output logic                      out_first_grp,
    output logic                      out_last_grp,
    output logic [DIM_W-1:0]          out_grp_idx,
    output logic                      busy,
    output logic                      done
);
    localparam int DW = LANES * DATA_W;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam logic [DIM_W-1:0] ONE_D = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DRAIN} state_t;
    state_t r_state;

    logic [DIM_W-1:0]  r_h, r_w, r_ng, r_gs, r_rs, r_cs, r_g, r_r, r_c;
    logic [ADDR_W-1:0] r_base, r_rd_addr;
    logic [LANES-1:0]  r_last_mask, r_done;

    // Tag pipe, one slot per cycle of memory latency
    logic              r_pv     [RD_LAT];
    logic              r_pfirst [RD_LAT];
    logic              r_plast  [RD_LAT];
    logic              r_pfinal [RD_LAT];
    logic [DIM_W-1:0]  r_pgrp   [RD_LAT];
    logic [LANES-1:0]  r_pmask  [RD_LAT];

    logic [DW-1:0]     r_fifo_data  [FIFO_DEPTH];
    logic [LANES-1:0]  r_fifo_mask  [FIFO_DEPTH];
    logic              r_fifo_first [FIFO_DEPTH];
    logic              r_fifo_last  [FIFO_DEPTH];
    logic              r_fifo_final [FIFO_DEPTH];
    logic [DIM_W-1:0]  r_fifo_grp   [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [DIM_W-1:0]  w_ng, w_rem, w_g_nxt, w_r_nxt, w_c_nxt;
    logic [LANES-1:0]  w_last_mask, w_tag_mask;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [IW-1:0]     w_inflight;
    logic [DW-1:0]     w_push_data;
    logic              w_zero, w_g_end, w_c_end, w_r_end, w_final;
    logic              w_issue, w_push, w_pop, w_abort_act;

    assign w_ng   = DIM_W'((32'(cfg_channels) + LANES - 1) / LANES);
    assign w_rem  = DIM_W'(32'(cfg_channels) - (32'(w_ng) - 32'd1) * LANES);
    assign w_zero = (cfg_tile_h == '0) | (cfg_tile_w == '0) | (cfg_channels == '0);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_last_mask[gi] = (32'(w_rem) > gi);
            assign w_push_data[gi*DATA_W +: DATA_W] =
                r_pmask[RD_LAT-1][gi] ? rd_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    assign w_g_end    = (r_g == r_ng - ONE_D);
    assign w_c_end    = (r_c == r_w - ONE_D);
    assign w_r_end    = (r_r == r_h - ONE_D);
    assign w_final    = w_g_end & w_c_end & w_r_end;
    assign w_tag_mask = w_g_end ? r_last_mask : '1;

    always_comb begin
        w_g_nxt = r_g + ONE_D;
        w_c_nxt = r_c;
        w_r_nxt = r_r;
        if (w_g_end) begin
            w_g_nxt = '0;
            if (w_c_end) begin
                w_c_nxt = '0;
                w_r_nxt = r_r + ONE_D;
            end else begin
                w_c_nxt = r_c + ONE_D;
            end
        end
    end

    assign w_addr_nxt = r_base + ADDR_W'(w_g_nxt) * ADDR_W'(r_gs)
                               + ADDR_W'(w_r_nxt) * ADDR_W'(r_rs)
                               + ADDR_W'(w_c_nxt) * ADDR_W'(r_cs);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + IW'(r_pv[i]);
    end

    // Occupancy uses pre-cycle counts so a same-cycle pop never frees a slot early
    assign busy        = (r_state != ST_IDLE);
    assign w_abort_act = abort & busy;
    assign w_issue     = (r_state == ST_WALK) & ~abort
                       & ((32'(w_inflight) + 32'(r_count)) < FIFO_DEPTH);
    assign w_push      = r_pv[RD_LAT-1];
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;
    assign rd_en       = w_issue;
    assign rd_addr     = r_rd_addr;
    assign done        = r_done[0];

    assign out_data      = out_valid ? r_fifo_data[r_rd_ptr]  : '0;
    assign out_lane_mask = out_valid ? r_fifo_mask[r_rd_ptr]  : '0;
    assign out_first_grp = out_valid & r_fifo_first[r_rd_ptr];
    assign out_last_grp  = out_valid & r_fifo_last[r_rd_ptr];
    assign out_grp_idx   = out_valid ? r_fifo_grp[r_rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= '0;
            r_h <= '0; r_w <= '0; r_ng <= '0; r_gs <= '0; r_rs <= '0; r_cs <= '0;
            r_g <= '0; r_r <= '0; r_c <= '0;
            r_base <= '0; r_rd_addr <= '0; r_last_mask <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_h <= cfg_tile_h; r_w <= cfg_tile_w; r_ng <= w_ng;
                    r_gs <= cfg_grp_stride; r_rs <= cfg_row_stride; r_cs <= cfg_col_stride;
                    r_base <= cfg_base_addr; r_rd_addr <= cfg_base_addr;
                    r_last_mask <= w_last_mask;
                    r_g <= '0; r_r <= '0; r_c <= '0;
                    if (w_zero) r_done <= LANES'(1);
                    else        r_state <= ST_WALK;
                end
                ST_WALK: if (abort) begin
                    r_state <= ST_IDLE;
                    r_done  <= LANES'(1);
                end else if (w_issue) begin
                    r_g <= w_g_nxt; r_r <= w_r_nxt; r_c <= w_c_nxt;
                    r_rd_addr <= w_addr_nxt;
                    if (w_final) r_state <= ST_DRAIN;
                end
                ST_DRAIN: if (abort || (w_pop && r_fifo_final[r_rd_ptr])) begin
                    r_state <= ST_IDLE;
                    r_done  <= LANES'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0; r_pfirst[i] <= 1'b0; r_plast[i] <= 1'b0;
                r_pfinal[i] <= 1'b0; r_pgrp[i] <= '0; r_pmask[i] <= '0;
            end
        end else begin
            r_pv[0]     <= w_issue;
            r_pfirst[0] <= (r_g == '0);
            r_plast[0]  <= w_g_end;
            r_pfinal[0] <= w_final;
            r_pgrp[0]   <= r_g;
            r_pmask[0]  <= w_tag_mask;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1]; r_pfirst[i] <= r_pfirst[i-1]; r_plast[i] <= r_plast[i-1];
                r_pfinal[i] <= r_pfinal[i-1]; r_pgrp[i] <= r_pgrp[i-1]; r_pmask[i] <= r_pmask[i-1];
            end
            // Killing the valids drops any data still returning from an aborted tile
            if (w_abort_act) for (int i = 0; i < RD_LAT; i++) r_pv[i] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
        end else if (w_abort_act) begin
            r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= w_push_data;
            r_fifo_mask[r_wr_ptr]  <= r_pmask[RD_LAT-1];
            r_fifo_first[r_wr_ptr] <= r_pfirst[RD_LAT-1];
            r_fifo_last[r_wr_ptr]  <= r_plast[RD_LAT-1];
            r_fifo_final[r_wr_ptr] <= r_pfinal[RD_LAT-1];
            r_fifo_grp[r_wr_ptr]   <= r_pgrp[RD_LAT-1];
        end
    end
endmodule
